// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX_MEM pipeline register.
// Optional signed-overflow trap is compiled in with `define EX_OVF_EN.
module ex_stage #(
    parameter logic [4:0] RA_REG = 5'd31,
    parameter logic [4:0] XP_REG = 5'd26
) (
    input  logic         clk,
    input  logic         reset_b,
    input  logic [229:0] ID_EX,
    input  logic         MEM_WB_RegWrite,
    input  logic [4:0]   MEM_WB_WriteReg,
    input  logic [31:0]  MEM_WB_RegWriteData,
    output logic [4:0]   ID_EX_Rt,
    output logic         ID_EX_MemRead,
    output logic         PCSrcB,
    output logic [31:0]  branch_target,
    output logic         ID_Flush,
    output logic         ovf_exception,
    output logic [105:0] EX_MEM
);

    logic [31:0] rs_data, rt_data, lu_data, pc_plus4, imm32;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  alu_fun;
    logic [1:0]  mem_to_reg, reg_dst;
    logic        alu_src1, alu_src2, sign, mem_read, mem_write, reg_write, lu_op, branch;

    assign rs_data       = ID_EX[31:0];
    assign rt_data       = ID_EX[63:32];
    assign rs            = ID_EX[68:64];
    assign rt            = ID_EX[73:69];
    assign rd            = ID_EX[78:74];
    assign sign          = ID_EX[79];
    assign alu_fun       = ID_EX[85:80];
    assign alu_src2      = ID_EX[86];
    assign alu_src1      = ID_EX[87];
    assign branch_target = ID_EX[119:88];
    assign mem_write     = ID_EX[120];
    assign mem_read      = ID_EX[121];
    assign reg_write     = ID_EX[122];
    assign mem_to_reg    = ID_EX[124:123];
    assign lu_data       = ID_EX[156:125];
    assign lu_op         = ID_EX[157];
    assign pc_plus4      = ID_EX[189:158];
    assign shamt         = ID_EX[194:190];
    assign imm32         = ID_EX[226:195];
    assign branch        = ID_EX[227];
    assign reg_dst       = ID_EX[229:228];

    logic [105:0] ex_mem_q, ex_mem_d;
    logic [31:0]  exm_val, fwd_rs, fwd_rt, a, b, alu_out, result;
    logic [4:0]   write_reg;
    logic         flag, ovf;

    // A jal/jalr sitting in EX_MEM carries its link value in the PC_Plus4 field, not in Result.
    assign exm_val = (ex_mem_q[73:72] == 2'b10) ? ex_mem_q[105:74] : ex_mem_q[31:0];

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] id_data,
                                        input logic [105:0] exm, input logic [31:0] exm_data,
                                        input logic wb_we, input logic [4:0] wb_reg,
                                        input logic [31:0] wb_data);
        if (exm[71] && exm[68:64] != 5'd0 && exm[68:64] == r)
            return exm_data;
        else if (wb_we && wb_reg != 5'd0 && wb_reg == r)
            return wb_data;
        else
            return id_data;
    endfunction

    always_comb begin
        fwd_rs = fwd(rs, rs_data, ex_mem_q, exm_val, MEM_WB_RegWrite, MEM_WB_WriteReg, MEM_WB_RegWriteData);
        fwd_rt = fwd(rt, rt_data, ex_mem_q, exm_val, MEM_WB_RegWrite, MEM_WB_WriteReg, MEM_WB_RegWriteData);
    end

    assign a = alu_src1 ? {27'b0, shamt} : fwd_rs;
    assign b = alu_src2 ? imm32 : fwd_rt;

    always_comb begin
        alu_out = '0;
        flag    = 1'b0;
        case (alu_fun[5:4])
            2'b00: alu_out = alu_fun[0] ? (a - b) : (a + b);
            2'b01: begin
                case (alu_fun[3:0])
                    4'b1000: alu_out = a & b;
                    4'b1110: alu_out = a | b;
                    4'b0110: alu_out = a ^ b;
                    4'b0001: alu_out = ~(a | b);
                    4'b1010: alu_out = a;
                    default: alu_out = '0;
                endcase
            end
            2'b10: begin
                case (alu_fun[1:0])
                    2'b00:   alu_out = b << a[4:0];
                    2'b01:   alu_out = b >> a[4:0];
                    2'b11:   alu_out = 32'($signed(b) >>> a[4:0]);
                    default: alu_out = '0;
                endcase
            end
            default: begin
                // Comparisons against zero look only at A and are always signed.
                case (alu_fun[3:1])
                    3'b001:  flag = (a == b);
                    3'b000:  flag = (a != b);
                    3'b010:  flag = sign ? ($signed(a) < $signed(b)) : (a < b);
                    3'b110:  flag = a[31] || (a == 32'd0);
                    3'b101:  flag = a[31];
                    3'b111:  flag = !a[31] && (a != 32'd0);
                    default: flag = 1'b0;
                endcase
                alu_out = {31'b0, flag};
            end
        endcase
    end

`ifdef EX_OVF_EN
    assign ovf = sign && (alu_fun[5:4] == 2'b00) && (alu_out[31] != a[31]) &&
                 (alu_fun[0] ? (a[31] != b[31]) : (a[31] == b[31]));
`else
    assign ovf = 1'b0;
`endif

    assign result = lu_op ? lu_data : alu_out;

    always_comb begin
        case (reg_dst)
            2'b00:   write_reg = rd;
            2'b01:   write_reg = rt;
            2'b10:   write_reg = RA_REG;
            default: write_reg = XP_REG;
        endcase
    end

    // An overflowing instruction is squashed by dropping all of its side-effect enables.
    always_comb begin
        ex_mem_d          = '0;
        ex_mem_d[31:0]    = result;
        ex_mem_d[63:32]   = fwd_rt;
        ex_mem_d[68:64]   = write_reg;
        ex_mem_d[69]      = mem_write && !ovf;
        ex_mem_d[70]      = mem_read && !ovf;
        ex_mem_d[71]      = reg_write && !ovf;
        ex_mem_d[73:72]   = mem_to_reg;
        ex_mem_d[105:74]  = pc_plus4;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            ex_mem_q <= '0;
        else
            ex_mem_q <= ex_mem_d;
    end

    assign EX_MEM        = ex_mem_q;
    assign PCSrcB        = branch && alu_out[0];
    assign ID_Flush      = PCSrcB;
    assign ID_EX_Rt      = rt;
    assign ID_EX_MemRead = mem_read;
    assign ovf_exception = ovf;

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline; consumer (reader) of the 230-bit ID_EX bundle the decode stage writes.
- Applies forwarding to the Rs and Rt operands, evaluates the ALU, and resolves conditional branches.
- Drives the ID_Flush and branch-redirect signals back to IF/ID, and feeds the load-use hazard detector.
- Registers its results into the 106-bit EX_MEM bundle for the memory stage.

Parameters:
- RA_REG, 31: link register written when RegDst=2'b10.
- XP_REG, 26: exception-PC register written when RegDst=2'b11.

Ports:
- clk  in  1  pipeline clock.
- reset_b  in  1  asynchronous active-low reset.
- ID_EX  in  230  decode bundle. Bit fields:
  - [31:0] RsData, [63:32] RtData, [68:64] Rs, [73:69] Rt, [78:74] Rd.
  - 87 ALUSrc1, 86 ALUSrc2, [85:80] ALUFun, 79 Sign.
  - [119:88] branch_address, 121 MemRead, 120 MemWrite.
  - [124:123] MemToReg, 122 RegWrite, 157 LUOp, [156:125] LUData.
  - [189:158] PC_Plus4, [194:190] Shamt, [226:195] Imm32, 227 Branch, [229:228] RegDst.
- MEM_WB_RegWrite  in  1  writeback enable.
- MEM_WB_WriteReg  in  5  writeback register.
- MEM_WB_RegWriteData  in  32  writeback data.
- ID_EX_Rt  out  5  ID_EX[73:69], to hazard detection.
- ID_EX_MemRead  out  1  ID_EX[121].
- PCSrcB  out  1  branch taken.
- branch_target  out  32  ID_EX[119:88].
- ID_Flush  out  1  equals PCSrcB.
- ovf_exception  out  1  see Optional Feature; 0 when compiled out.
- EX_MEM  out reg  106  memory-stage bundle. Bit fields:
  - [31:0] Result, [63:32] StoreData, [68:64] WriteReg.
  - 69 MemWrite, 70 MemRead, 71 RegWrite, [73:72] MemToReg, [105:74] PC_Plus4.

Behaviour:
- Reset: EX_MEM=0, asynchronously on reset_b low. All other outputs are combinational from ID_EX and EX_MEM. Reset mid-instruction discards it.
- Forwarding, Rs (same for Rt). Priority order:
  - Use EX_MEM when EX_MEM[71]=1 and EX_MEM[68:64]!=0 and EX_MEM[68:64]==Rs. Forwarded value is PC_Plus4 from EX_MEM[105:74] if EX_MEM[73:72]==2'b10, else EX_MEM[31:0].
  - Else use MEM_WB_RegWriteData when MEM_WB_RegWrite=1, MEM_WB_WriteReg!=0 and equal to Rs.
  - Else use ID_EX RsData.
  - Load data is never forwarded from EX_MEM; the hazard detector bubbles load-use.
- Operands: A = ALUSrc1 ? {27'b0,Shamt} : fwdRs. B = ALUSrc2 ? Imm32 : fwdRt.
- ALUFun[5:4], arithmetic:
  - 00: ALUFun[0]=0 gives A+B, 1 gives A-B (32-bit wrap).
  - 01: [3:0] 1000 AND, 1110 OR, 0110 XOR, 0001 NOR, 1010 pass A; other codes give 0.
  - 10: shift B by A[4:0]; [1:0] 00 SLL, 01 SRL, 11 SRA, 10 gives 0.
  - 11: result {31'b0,flag}; [3:1] 001 EQ, 000 NE, 010 LT, 110 A<=0, 101 A<0, 111 A>0, others 0.
  - LT is signed when Sign=1, unsigned when Sign=0. Zero-compares are always signed.
- Result = LUOp ? LUData : ALUOut.
- WriteReg by RegDst: 00 Rd, 01 Rt, 10 RA_REG, 11 XP_REG.
- Branch: PCSrcB = Branch & ALUOut[0], same cycle (0-cycle resolve). ID_Flush=PCSrcB.
- Posedge clk captures the EX_MEM fields: Result, fwdRt as StoreData, WriteReg, the control bits and PC_Plus4. One-cycle latency; there is no stall input.
- A bubble or flush arriving as ID_EX=0 produces EX_MEM with all controls 0.
- A taken branch writes an EX_MEM with RegWrite=MemWrite=MemRead=0, because its decoded controls are 0.

Optional Feature:
- EX_OVF_EN defined: signed overflow checked when Sign=1 and ALUFun[5:4]=00.
  - Add overflow: sign(A)==sign(B) and sign(sum)!=sign(A).
  - Sub overflow: sign(A)!=sign(B) and sign(diff)!=sign(A).
  - On overflow: ovf_exception=1 combinationally, and EX_MEM captures RegWrite=MemWrite=MemRead=0.
- Undefined: ovf_exception tied 0; no suppression.

Test Plan:
- add, Rs=5, Rt=7, no forwarding, RegDst=00, Rd=3 -> next cycle EX_MEM[31:0]=12, [68:64]=3, [71]=1.
- Back-to-back dependency: EX_MEM holds r3=12 with RegWrite, new ID_EX uses Rs=3, RsData=0, sub Imm32=2 -> Result=10. The same match against MEM_WB only gives MEM_WB data; both matching gives EX_MEM priority.
- beq with forwarded Rs=Rt=9 (ALUFun 110011), branch_address=0x40 -> PCSrcB=1, ID_Flush=1, branch_target=0x40, EX_MEM controls 0.
- jal in EX_MEM (MemToReg=10, PC_Plus4=0x1C, WriteReg=31), next instruction reads r31 -> A=0x1C. Write to r0 is never forwarded.
- SRA: B=0x80000000, Shamt=4, ALUSrc1=1 -> 0xF8000000. LT: A=0xFFFFFFFF, B=1 gives 1 with Sign=1 and 0 with Sign=0.
- EX_OVF_EN: add 0x7FFFFFFF+1, Sign=1 -> ovf_exception=1, EX_MEM[71]=0. reset_b pulsed low mid-sequence -> EX_MEM=0 immediately.
